// File: rtl/alu_share_ctrl_if.sv
// Request/response and ALU-side bundle for the shared ALU controller.
// The controller takes the slave view; the pipeline and ALU take the master view.
interface alu_share_ctrl_if #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_result;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp0_ready, resp1_ready, alu_result,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_result,
        output alu_sel, alu_a, alu_b, busy, op_count
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp0_ready, resp1_ready, alu_result,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_result,
        input  alu_sel, alu_a, alu_b, busy, op_count
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one 24-bit ALU between execute (req0)
// and address generation (req1): latch, evaluate, respond.
module alu_share_ctrl #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 16
) (
    input logic          Clock,
    input logic          Reset,
    alu_share_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CNT_W-1:0] cnt;
    logic             resp0_v;
    logic             resp1_v;
    logic             gnt0;
    logic             gnt1;
    logic             take;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
        take = owner ? bus.resp1_ready : bus.resp0_ready;
    end

    assign bus.req0_ready  = (state == IDLE) && gnt0;
    assign bus.req1_ready  = (state == IDLE) && gnt1;
    assign bus.resp0_valid = resp0_v;
    assign bus.resp1_valid = resp1_v;
    assign bus.resp_result = result_reg;
    assign bus.alu_sel     = {1'b0, op_reg};
    assign bus.alu_a       = a_reg;
    assign bus.alu_b       = b_reg;
    assign bus.busy        = (state != IDLE);
    assign bus.op_count    = cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            cnt        <= '0;
            resp0_v    <= 1'b0;
            resp1_v    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        gnt0: begin
                            owner      <= 1'b0;
                            last_grant <= 1'b0;
                            op_reg     <= bus.req0_op;
                            a_reg      <= bus.req0_a;
                            b_reg      <= bus.req0_b;
                            state      <= EXEC;
                        end
                        gnt1: begin
                            owner      <= 1'b1;
                            last_grant <= 1'b1;
                            op_reg     <= bus.req1_op;
                            a_reg      <= bus.req1_a;
                            b_reg      <= bus.req1_b;
                            state      <= EXEC;
                        end
                        default: ;
                    endcase
                end
                EXEC: begin
                    result_reg <= bus.alu_result;
                    resp0_v    <= !owner;
                    resp1_v    <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (take) begin
                        resp0_v <= 1'b0;
                        resp1_v <= 1'b0;
                        cnt     <= cnt + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed table, corner
// sequences and randomized traffic against a transaction-level model.
module tb_alu_share_ctrl;

    localparam int W  = 24;
    localparam int CW = 4;

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    alu_share_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    alu_share_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    function automatic logic [W-1:0] alu_f(logic [1:0] op,
                                           logic [W-1:0] a,
                                           logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a + b;
            default: return (a < b) ? W'(1) : W'(0);
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_sel[1:0], bus.alu_a, bus.alu_b);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 waiting, 1 computing, 2 responding.
    int         m_phase;
    logic       m_owner;
    logic       m_last;
    logic [1:0] m_op;
    logic [W-1:0] m_a, m_b, m_res;
    int         m_cnt;

    task automatic model_reset();
        m_phase = 0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_op    = '0;
        m_a     = '0;
        m_b     = '0;
        m_res   = '0;
        m_cnt   = 0;
    endtask

    // {found, index} of the requester that should win this cycle.
    function automatic logic [1:0] winner();
        if (bus.req0_valid && bus.req1_valid)
            return {1'b1, m_last ? 1'b0 : 1'b1};
        if (bus.req0_valid) return 2'b10;
        if (bus.req1_valid) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_check();
        logic [1:0] w;
        logic       idle;
        w    = winner();
        idle = (m_phase == 0);
        chk("req0_ready", 32'(bus.req0_ready), 32'(idle && w == 2'b10));
        chk("req1_ready", 32'(bus.req1_ready), 32'(idle && w == 2'b11));
        chk("resp0_valid", 32'(bus.resp0_valid),
            32'(m_phase == 2 && !m_owner));
        chk("resp1_valid", 32'(bus.resp1_valid),
            32'(m_phase == 2 && m_owner));
        chk("busy", 32'(bus.busy), 32'(!idle));
        chk("op_count", 32'(bus.op_count), 32'(m_cnt));
        chk("alu_sel", 32'(bus.alu_sel), 32'({1'b0, m_op}));
        chk("alu_a", 32'(bus.alu_a), 32'(m_a));
        chk("alu_b", 32'(bus.alu_b), 32'(m_b));
        if (m_phase == 2)
            chk("resp_result", 32'(bus.resp_result), 32'(m_res));
    endtask

    task automatic model_step();
        logic [1:0] w;
        w = winner();
        if (m_phase == 0) begin
            if (w[1]) begin
                m_owner = w[0];
                m_last  = w[0];
                m_op    = w[0] ? bus.req1_op : bus.req0_op;
                m_a     = w[0] ? bus.req1_a  : bus.req0_a;
                m_b     = w[0] ? bus.req1_b  : bus.req0_b;
                m_res   = alu_f(m_op, m_a, m_b);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_owner ? bus.resp1_ready : bus.resp0_ready) begin
            m_phase = 0;
            m_cnt   = (m_cnt + 1) % (1 << CW);
        end
    endtask

    task automatic tick_check();
        @(negedge Clock);
        model_check();
    endtask

    task automatic tick_adv();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic tick();
        tick_check();
        tick_adv();
    endtask

    task automatic set_req(logic r, logic v, logic [1:0] op,
                           logic [W-1:0] a, logic [W-1:0] b);
        if (!r) begin
            bus.req0_valid = v;
            bus.req0_op    = op;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end else begin
            bus.req1_valid = v;
            bus.req1_op    = op;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end
    endtask

    task automatic clear_reqs();
        set_req(1'b0, 1'b0, 2'd0, '0, '0);
        set_req(1'b1, 1'b0, 2'd0, '0, '0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        clear_reqs();
        model_reset();
        @(posedge Clock);
        #1;
        tick_check();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    typedef struct {
        logic         req;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
    } vec_t;

    vec_t   tv[8];
    logic   gq[$];
    logic [CW-1:0] prev_cnt;
    logic   wrap_seen;

    initial begin
        tv[0] = '{1'b0, 2'd2, 24'h00000F, 24'h000001, 24'h000010};
        tv[1] = '{1'b0, 2'd0, 24'hFF00FF, 24'h0F0F0F, 24'h0F000F};
        tv[2] = '{1'b1, 2'd1, 24'h000001, 24'h800000, 24'h800001};
        tv[3] = '{1'b1, 2'd3, 24'h000003, 24'h000007, 24'h000001};
        tv[4] = '{1'b0, 2'd2, 24'hFFFFFF, 24'h000001, 24'h000000};
        tv[5] = '{1'b1, 2'd3, 24'h000007, 24'h000003, 24'h000000};
        tv[6] = '{1'b0, 2'd3, 24'h000005, 24'h000005, 24'h000000};
        tv[7] = '{1'b1, 2'd2, 24'h7FFFFF, 24'h000001, 24'h800000};

        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        do_reset();

        // Directed single operations, operands scrambled after handshake.
        for (int i = 0; i < 8; i++) begin
            set_req(tv[i].req, 1'b1, tv[i].op, tv[i].a, tv[i].b);
            tick_check();
            chk("tv_ready", 32'(tv[i].req ? bus.req1_ready
                                          : bus.req0_ready), 32'd1);
            tick_adv();
            set_req(tv[i].req, 1'b0, 2'($urandom), W'($urandom),
                    W'($urandom));
            tick_check();
            chk("tv_sel", 32'(bus.alu_sel), 32'({1'b0, tv[i].op}));
            tick_adv();
            tick_check();
            chk("tv_valid", 32'(tv[i].req ? bus.resp1_valid
                                          : bus.resp0_valid), 32'd1);
            chk("tv_result", 32'(bus.resp_result), 32'(tv[i].res));
            tick_adv();
        end
        clear_reqs();
        tick();

        // Contention from reset: grants must alternate 0,1,0,1.
        do_reset();
        set_req(1'b0, 1'b1, 2'd0, 24'hFF00FF, 24'h0F0F0F);
        set_req(1'b1, 1'b1, 2'd1, 24'h000001, 24'h800000);
        for (int c = 0; c < 40 && gq.size() < 4; c++) begin
            tick_check();
            if (bus.req0_ready) gq.push_back(1'b0);
            if (bus.req1_ready) gq.push_back(1'b1);
            if (bus.resp0_valid)
                chk("cont_r0", 32'(bus.resp_result), 32'h0F000F);
            if (bus.resp1_valid)
                chk("cont_r1", 32'(bus.resp_result), 32'h800001);
            tick_adv();
        end
        chk("cont_grants", 32'(gq.size()), 32'd4);
        foreach (gq[i]) chk("cont_order", 32'(gq[i]), 32'(i % 2));
        clear_reqs();
        for (int c = 0; c < 3; c++) tick();

        // Backpressure on requester 1 while requester 0 waits.
        set_req(1'b1, 1'b1, 2'd3, 24'h000003, 24'h000007);
        bus.resp1_ready = 1'b0;
        tick();
        set_req(1'b1, 1'b0, 2'd0, '0, '0);
        set_req(1'b0, 1'b1, 2'd2, 24'h000100, 24'h000001);
        tick();
        for (int c = 0; c < 5; c++) begin
            tick_check();
            chk("bp_valid", 32'(bus.resp1_valid), 32'd1);
            chk("bp_result", 32'(bus.resp_result), 32'd1);
            chk("bp_r0_ready", 32'(bus.req0_ready), 32'd0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
            tick_adv();
        end
        bus.resp1_ready = 1'b1;
        tick();
        tick_check();
        chk("bp_next_grant", 32'(bus.req0_ready), 32'd1);
        tick_adv();
        clear_reqs();
        for (int c = 0; c < 3; c++) tick();

        // Asynchronous reset while the ALU is evaluating.
        set_req(1'b0, 1'b1, 2'd2, 24'h000123, 24'h000456);
        tick();
        Reset = 1'b1;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_r0v", 32'(bus.resp0_valid), 32'd0);
        chk("ar_r1v", 32'(bus.resp1_valid), 32'd0);
        chk("ar_cnt", 32'(bus.op_count), 32'd0);
        chk("ar_sel", 32'(bus.alu_sel), 32'd0);
        chk("ar_a", 32'(bus.alu_a), 32'd0);
        chk("ar_result", 32'(bus.resp_result), 32'd0);
        clear_reqs();
        model_reset();
        #1;
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        set_req(1'b1, 1'b1, 2'd1, 24'h00F000, 24'h00000F);
        tick();
        clear_reqs();
        for (int c = 0; c < 3; c++) tick();

        // 17 back-to-back ops on a 4-bit counter must wrap through zero.
        do_reset();
        wrap_seen = 1'b0;
        prev_cnt  = '0;
        for (int c = 0; c < 51; c++) begin
            set_req(1'b0, 1'b1, 2'($urandom), W'($urandom), W'($urandom));
            tick_check();
            if (prev_cnt == 4'd15 && bus.op_count == 4'd0) wrap_seen = 1'b1;
            prev_cnt = bus.op_count;
            tick_adv();
        end
        clear_reqs();
        tick_check();
        chk("wrap_seen", 32'(wrap_seen), 32'd1);
        chk("wrap_final", 32'(bus.op_count), 32'd1);
        tick_adv();

        // Randomized traffic with random response backpressure.
        for (int c = 0; c < 400; c++) begin
            set_req(1'b0, $urandom_range(0, 2) != 0, 2'($urandom),
                    W'($urandom), W'($urandom));
            set_req(1'b1, $urandom_range(0, 2) != 0, 2'($urandom),
                    W'($urandom), W'($urandom));
            bus.resp0_ready = $urandom_range(0, 3) != 0;
            bus.resp1_ready = $urandom_range(0, 3) != 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
